// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Fills the instruction memory from a byte stream (16-bit
//               little-endian word count, then little-endian 32-bit words)
//               and holds the core in reset until the program is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // One extra bit so the unsigned compare can never truncate DEPTH.
  localparam logic [16:0] DEPTH_EXT = 17'(DEPTH);

  logic [2:0]        state;
  logic [15:0]       count;
  logic [15:0]       word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       wbuf;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic [15:0]       hdr_count;
  logic [15:0]       word_next;

  // Every output is a pure decode of the state register or a register itself,
  // so reset reaches all outputs asynchronously.
  assign byte_ready_o = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
  assign imem_we_o    = (state == S_WRITE);
  assign cpu_reset_o  = (state != S_DONE);
  assign done_o       = (state == S_DONE);
  assign error_o      = (state == S_ERR);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;

  assign accept    = byte_ready_o & byte_valid_i;
  assign hdr_count = {byte_i, count[7:0]};
  assign word_next = word_idx + 16'd1;

  // Loader FSM: header capture, word assembly and write sequencing.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= S_IDLE;
      count    <= 16'd0;
      word_idx <= 16'd0;
      byte_idx <= 2'd0;
      wbuf     <= 24'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state    <= S_HDR0;
            count    <= 16'd0;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
          end
        end

        S_HDR0: begin
          if (accept) begin
            count <= {8'h00, byte_i};
            state <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (accept) begin
            count    <= hdr_count;
            byte_idx <= 2'd0;
            word_idx <= 16'd0;
            if (hdr_count == 16'd0) begin
              state <= S_DONE;
            end else if ({1'b0, hdr_count} > DEPTH_EXT) begin
              state <= S_ERR;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            if (byte_idx == 2'd3) begin
              // Address and data are latched here so they are stable for the
              // whole WRITE cycle and then hold until the next word.
              addr_q   <= ADDR_W'({word_idx, 2'b00});
              wdata_q  <= {byte_i, wbuf};
              byte_idx <= 2'd0;
              state    <= S_WRITE;
            end else begin
              case (byte_idx)
                2'd0:    wbuf[7:0]   <= byte_i;
                2'd1:    wbuf[15:8]  <= byte_i;
                default: wbuf[23:16] <= byte_i;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        S_WRITE: begin
          word_idx <= word_next;
          state    <= (word_next == count) ? S_DONE : S_DATA;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader. Loads are built from word
//               lists; the expected memory writes are queued from the word list
//               and a monitor pops them whenever the DUT strobes a write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_reset_o;
  logic        done_o;
  logic        error_o;

  int checks = 0;
  int passed = 0;

  logic [63:0] exp_q[$];
  logic [31:0] words[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .cpu_reset_o  (cpu_reset_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the DUT stalls somewhere no bounded wait catches.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset_n && imem_we_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 imem_addr_o, imem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {32'd0, imem_addr_o}, {32'd0, e[63:32]});
        check("write_data", {32'd0, imem_wdata_o}, {32'd0, e[31:0]});
        check("ready_low_in_write", {63'd0, byte_ready_o}, 64'd0);
      end
    end
  end

  // Offers one byte (optionally after random idle cycles) and returns at the
  // falling edge after the rising edge that transferred it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cyc;
    while (gaps && $urandom_range(0, 2) == 0) begin
      byte_valid_i = 1'b0;
      byte_i       = 8'($urandom);
      @(negedge clk);
    end
    byte_i       = b;
    byte_valid_i = 1'b1;
    cyc          = 0;
    while (!byte_ready_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!byte_ready_o) begin
      checks++;
      $display("FAIL byte_timeout: got ready=0 for 50 cycles expected ready=1");
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic start_load();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_ready", {63'd0, byte_ready_o}, 64'd1);
    check("start_done_clr", {62'd0, done_o, error_o}, 64'd0);
    check("start_cpu_reset", {63'd0, cpu_reset_o}, 64'd1);
  endtask

  // Runs one load of `cnt` words taken from `words`. abort_after >= 0 drops
  // reset after that many data bytes; start_mid pulses start_i during DATA.
  task automatic run_load(input int cnt, input bit gaps, input int abort_after, input bit start_mid);
    logic [15:0] c;
    logic [31:0] w;
    int          sent;
    c = cnt[15:0];
    // Reference: word i lands at byte address 4*i, if it is fully delivered.
    if (cnt <= DEPTH) begin
      for (int i = 0; i < cnt; i++) begin
        if (abort_after < 0 || 4 * (i + 1) <= abort_after)
          exp_q.push_back({32'(i * 4), words[i]});
      end
    end
    start_load();
    send_byte(c[7:0], gaps);
    send_byte(c[15:8], gaps);
    if (cnt == 0) begin
      check("zero_done", {63'd0, done_o}, 64'd1);
      check("zero_cpu_reset", {63'd0, cpu_reset_o}, 64'd0);
      return;
    end
    if (cnt > DEPTH) begin
      check("ovf_error", {63'd0, error_o}, 64'd1);
      check("ovf_state", {61'd0, cpu_reset_o, byte_ready_o, done_o}, 64'b100);
      repeat (5) @(negedge clk);
      check("ovf_hold", {62'd0, error_o, byte_ready_o}, 64'b10);
      return;
    end
    sent = 0;
    for (int i = 0; i < cnt; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        if (abort_after >= 0 && sent == abort_after) begin
          reset_n = 1'b0;
          #1;
          check("rst_ready", {63'd0, byte_ready_o}, 64'd0);
          check("rst_we", {63'd0, imem_we_o}, 64'd0);
          check("rst_addr_data", {imem_addr_o, imem_wdata_o}, 64'd0);
          check("rst_flags", {61'd0, cpu_reset_o, done_o, error_o}, 64'b100);
          check("rst_queue", 64'(exp_q.size()), 64'd0);
          repeat (3) @(negedge clk);
          reset_n = 1'b1;
          repeat (3) @(negedge clk);
          check("post_rst_idle", {60'd0, byte_ready_o, cpu_reset_o, done_o, error_o}, 64'b0100);
          return;
        end
        if (start_mid && i == 0 && k == 1) start_i = 1'b1;
        send_byte(w[8*k +: 8], gaps);
        start_i = 1'b0;
        sent++;
      end
    end
    check("last_write_strobe", {63'd0, imem_we_o}, 64'd1);
    @(negedge clk);
    check("done_after_write", {62'd0, done_o, error_o}, 64'b10);
    check("cpu_released", {63'd0, cpu_reset_o}, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    reset_n      = 1'b0;
    start_i      = 1'b0;
    byte_i       = 8'd0;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready_we", {62'd0, byte_ready_o, imem_we_o}, 64'd0);
    check("reset_addr_data", {imem_addr_o, imem_wdata_o}, 64'd0);
    check("reset_flags", {61'd0, cpu_reset_o, done_o, error_o}, 64'b100);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic two-word program, valid held high.
    words.delete();
    words.push_back(32'h12345678);
    words.push_back(32'hDEADBEEF);
    run_load(2, 1'b0, -1, 1'b0);

    // Same program with random gaps; start from DONE loads again from 0.
    run_load(2, 1'b1, -1, 1'b0);

    // Zero and overflow headers.
    run_load(0, 1'b1, -1, 1'b0);
    run_load(257, 1'b0, -1, 1'b0);

    // Capacity boundary.
    fill_random(DEPTH);
    run_load(DEPTH, 1'b0, -1, 1'b0);

    // Reset after 5 data bytes, then a fresh load from IDLE.
    fill_random(2);
    run_load(2, 1'b0, 5, 1'b0);

    // start_i pulsed during DATA is ignored.
    fill_random(3);
    run_load(3, 1'b1, -1, 1'b1);

    // Random programs with random gaps.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 24);
      fill_random(n);
      run_load(n, 1'b1, -1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
